// File: rtl/em_pipe_reg_pkg.sv
// em_pipe_reg_pkg: constants shared by the E/M pipeline register and its
// helpers.
//   TW          Tnew counter width
//   TNEW_ZERO   Tnew value meaning "result is available now"
//   WD_ALU      M-stage result select: ALU output
//   WD_PC8      M-stage result select: link address (PC + 8)
//   BUBBLE_PC   PC value carried by a bubble (reset or flush)
package em_pipe_reg_pkg;

   localparam int unsigned TW = 2;

   localparam logic [TW-1:0] TNEW_ZERO = 2'd0;

   localparam logic WD_ALU = 1'b0;
   localparam logic WD_PC8 = 1'b1;

   localparam logic [31:0] BUBBLE_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter32.sv
// sat_counter32: 32-bit incrementer that sticks at all-ones.
//   clk    rising-edge clock
//   reset  asynchronous, active-high clear
//   inc    count this edge
//   count  current value
module sat_counter32 (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   output logic [31:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/em_pipe_reg.sv
// em_pipe_reg: E/M pipeline register of the five-stage MIPS core.
// Captures the E-stage result, destination register, store data, PC and
// instruction, ages the Tnew forwarding counter by one stage and presents a
// forwarding source (valid, data) built only from registered state.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   en                         1 = load E stage, 0 = hold
//   clr                        synchronous flush (bubble), beats en
//   E_PC, E_Instr, E_ALU_O,
//   E_MUXE_RegDst_O, E_RT_Data,
//   E_Tnew, E_WDSel            E-stage inputs
//   M_PC, M_Instr, M_ALU_O,
//   M_RT_Data, M_A3, M_Tnew,
//   M_WDSel                    registered M-stage copies (Tnew aged)
//   M_Fwd_Valid, M_Fwd_Data    forwarding source for the hazard unit
//   perf_bubble_cnt,
//   perf_hold_cnt              performance counters
//
// Build option: EM_PERF_EN enables the two saturating performance counters;
// without it both counter ports are tied to zero and no counter flops exist.
module em_pipe_reg #(
   parameter int unsigned DW        = 32,
   parameter int unsigned AW        = 5,
   parameter int unsigned TW        = 2,
   parameter logic [31:0] BUBBLE_PC = em_pipe_reg_pkg::BUBBLE_PC
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          clr,
   input  logic [DW-1:0] E_PC,
   input  logic [DW-1:0] E_Instr,
   input  logic [DW-1:0] E_ALU_O,
   input  logic [AW-1:0] E_MUXE_RegDst_O,
   input  logic [DW-1:0] E_RT_Data,
   input  logic [TW-1:0] E_Tnew,
   input  logic          E_WDSel,
   output logic [DW-1:0] M_PC,
   output logic [DW-1:0] M_Instr,
   output logic [DW-1:0] M_ALU_O,
   output logic [DW-1:0] M_RT_Data,
   output logic [AW-1:0] M_A3,
   output logic [TW-1:0] M_Tnew,
   output logic          M_WDSel,
   output logic          M_Fwd_Valid,
   output logic [DW-1:0] M_Fwd_Data,
   output logic [31:0]   perf_bubble_cnt,
   output logic [31:0]   perf_hold_cnt
);

   import em_pipe_reg_pkg::*;

   logic [TW-1:0] tnew_aged;

   // Saturating decrement: an instruction already producing stays at zero.
   always_comb begin
      tnew_aged = '0;
      if (E_Tnew != TW'(TNEW_ZERO)) begin
         tnew_aged = E_Tnew - TW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         M_PC      <= DW'(BUBBLE_PC);
         M_Instr   <= '0;
         M_ALU_O   <= '0;
         M_RT_Data <= '0;
         M_A3      <= '0;
         M_Tnew    <= '0;
         M_WDSel   <= WD_ALU;
      end else if (clr) begin
         M_PC      <= DW'(BUBBLE_PC);
         M_Instr   <= '0;
         M_ALU_O   <= '0;
         M_RT_Data <= '0;
         M_A3      <= '0;
         M_Tnew    <= '0;
         M_WDSel   <= WD_ALU;
      end else if (en) begin
         M_PC      <= E_PC;
         M_Instr   <= E_Instr;
         M_ALU_O   <= E_ALU_O;
         M_RT_Data <= E_RT_Data;
         M_A3      <= E_MUXE_RegDst_O;
         M_Tnew    <= tnew_aged;
         M_WDSel   <= E_WDSel;
      end
   end

   // $0 is never a forwarding target; A3 = 0 also encodes "no write".
   always_comb begin
      M_Fwd_Valid = (M_A3 != '0) && (M_Tnew == TW'(TNEW_ZERO));
      M_Fwd_Data  = (M_WDSel == WD_ALU) ? M_ALU_O : (M_PC + DW'(8));
   end

`ifdef EM_PERF_EN
   logic bubble_inc;
   logic hold_inc;

   // A load of a zero instruction word is a bubble arriving from upstream.
   always_comb begin
      bubble_inc = clr || (en && (E_Instr == '0));
      hold_inc   = !clr && !en;
   end

   sat_counter32 u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (bubble_inc),
      .count (perf_bubble_cnt)
   );

   sat_counter32 u_hold_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (hold_inc),
      .count (perf_hold_cnt)
   );
`else
   assign perf_bubble_cnt = '0;
   assign perf_hold_cnt   = '0;
`endif

endmodule

// File: tb/tb_em_pipe_reg.sv
// tb_em_pipe_reg: table-driven vectors, hand-written corner sequences and a
// randomized run against a behavioural model of the E/M register.
module tb_em_pipe_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        clr;
   logic [31:0] E_PC;
   logic [31:0] E_Instr;
   logic [31:0] E_ALU_O;
   logic [4:0]  E_MUXE_RegDst_O;
   logic [31:0] E_RT_Data;
   logic [1:0]  E_Tnew;
   logic        E_WDSel;
   logic [31:0] M_PC;
   logic [31:0] M_Instr;
   logic [31:0] M_ALU_O;
   logic [31:0] M_RT_Data;
   logic [4:0]  M_A3;
   logic [1:0]  M_Tnew;
   logic        M_WDSel;
   logic        M_Fwd_Valid;
   logic [31:0] M_Fwd_Data;
   logic [31:0] perf_bubble_cnt;
   logic [31:0] perf_hold_cnt;

   int vectors     = 0;
   int miscompares = 0;

   em_pipe_reg #(
      .DW        (32),
      .AW        (5),
      .TW        (2),
      .BUBBLE_PC (32'h0000_0000)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .en              (en),
      .clr             (clr),
      .E_PC            (E_PC),
      .E_Instr         (E_Instr),
      .E_ALU_O         (E_ALU_O),
      .E_MUXE_RegDst_O (E_MUXE_RegDst_O),
      .E_RT_Data       (E_RT_Data),
      .E_Tnew          (E_Tnew),
      .E_WDSel         (E_WDSel),
      .M_PC            (M_PC),
      .M_Instr         (M_Instr),
      .M_ALU_O         (M_ALU_O),
      .M_RT_Data       (M_RT_Data),
      .M_A3            (M_A3),
      .M_Tnew          (M_Tnew),
      .M_WDSel         (M_WDSel),
      .M_Fwd_Valid     (M_Fwd_Valid),
      .M_Fwd_Data      (M_Fwd_Data),
      .perf_bubble_cnt (perf_bubble_cnt),
      .perf_hold_cnt   (perf_hold_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Expected contents of the M stage.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] alu;
      logic [31:0] rtd;
      logic [4:0]  a3;
      logic [1:0]  tn;
      logic        wd;
      logic        fv;
      logic [31:0] fd;
   } exp_t;

   typedef struct {
      logic        en;
      logic        clr;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] alu;
      logic [31:0] rtd;
      logic [4:0]  a3;
      logic [1:0]  tn;
      logic        wd;
      exp_t        x;
   } vec_t;

   vec_t tbl[$];

   // Behavioural model state
   logic [31:0] m_pc, m_instr, m_alu, m_rtd;
   logic [4:0]  m_a3;
   logic [1:0]  m_tn;
   logic        m_wd;
   logic [31:0] m_bub, m_hold;

   task automatic check(input string name, input exp_t x);
      vectors++;
      if (M_PC !== x.pc || M_Instr !== x.instr || M_ALU_O !== x.alu ||
          M_RT_Data !== x.rtd || M_A3 !== x.a3 || M_Tnew !== x.tn ||
          M_WDSel !== x.wd || M_Fwd_Valid !== x.fv || M_Fwd_Data !== x.fd) begin
         miscompares++;
         $display("FAIL %s: got pc=%h in=%h alu=%h rt=%h a3=%0d tn=%0d wd=%b fv=%b fd=%h exp pc=%h in=%h alu=%h rt=%h a3=%0d tn=%0d wd=%b fv=%b fd=%h",
                  name, M_PC, M_Instr, M_ALU_O, M_RT_Data, M_A3, M_Tnew, M_WDSel,
                  M_Fwd_Valid, M_Fwd_Data, x.pc, x.instr, x.alu, x.rtd, x.a3,
                  x.tn, x.wd, x.fv, x.fd);
      end
   endtask

   task automatic check_cnt(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h exp %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic e, input logic c, input logic [31:0] pc,
                        input logic [31:0] instr, input logic [31:0] alu,
                        input logic [31:0] rtd, input logic [4:0] a3,
                        input logic [1:0] tn, input logic wd);
      en = e; clr = c; E_PC = pc; E_Instr = instr; E_ALU_O = alu;
      E_RT_Data = rtd; E_MUXE_RegDst_O = a3; E_Tnew = tn; E_WDSel = wd;
   endtask

   function automatic exp_t bubble();
      exp_t b;
      b = '{pc: 32'h0, instr: 32'h0, alu: 32'h0, rtd: 32'h0, a3: 5'd0,
            tn: 2'd0, wd: 1'b0, fv: 1'b0, fd: 32'h0};
      return b;
   endfunction

   function automatic exp_t model_exp();
      exp_t x;
      x.pc = m_pc; x.instr = m_instr; x.alu = m_alu; x.rtd = m_rtd;
      x.a3 = m_a3; x.tn = m_tn; x.wd = m_wd;
      x.fv = (m_a3 != 0) && (m_tn == 0);
      x.fd = m_wd ? m_pc + 32'd8 : m_alu;
      return x;
   endfunction

   task automatic model_reset();
      m_pc = 0; m_instr = 0; m_alu = 0; m_rtd = 0; m_a3 = 0; m_tn = 0;
      m_wd = 0; m_bub = 0; m_hold = 0;
   endtask

   // Applies the edge rules to the model using the currently driven inputs.
   task automatic model_edge();
      int t;
      if (clr || (en && E_Instr == 0)) begin
         if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
      end
      if (!clr && !en) begin
         if (m_hold != 32'hFFFF_FFFF) m_hold = m_hold + 1;
      end
      if (clr) begin
         m_pc = 0; m_instr = 0; m_alu = 0; m_rtd = 0; m_a3 = 0; m_tn = 0; m_wd = 0;
      end else if (en) begin
         t = int'(E_Tnew) - 1;
         m_pc = E_PC; m_instr = E_Instr; m_alu = E_ALU_O; m_rtd = E_RT_Data;
         m_a3 = E_MUXE_RegDst_O; m_tn = (t < 0) ? 2'd0 : 2'(t); m_wd = E_WDSel;
      end
   endtask

   task automatic check_perf(input string name, input logic [31:0] bub,
                             input logic [31:0] hold);
`ifdef EM_PERF_EN
      check_cnt({name, "_bubble"}, perf_bubble_cnt, bub);
      check_cnt({name, "_hold"}, perf_hold_cnt, hold);
`else
      check_cnt({name, "_bubble_off"}, perf_bubble_cnt, 32'h0);
      check_cnt({name, "_hold_off"}, perf_hold_cnt, 32'h0);
`endif
   endtask

   exp_t xb;
   exp_t xl;

   initial begin
      xb = bubble();
      // rows: en clr pc instr alu rtd a3 tnew wdsel | expected M stage
      tbl.push_back('{1'b1, 1'b0, 32'h3000, 32'h8C08_0004, 32'hAB, 32'h1111, 5'd8, 2'd2, 1'b0,
                      '{32'h3000, 32'h8C08_0004, 32'hAB, 32'h1111, 5'd8, 2'd1, 1'b0, 1'b0, 32'hAB}});
      tbl.push_back('{1'b1, 1'b0, 32'h3004, 32'h0109_4020, 32'hAB, 32'h2222, 5'd8, 2'd0, 1'b0,
                      '{32'h3004, 32'h0109_4020, 32'hAB, 32'h2222, 5'd8, 2'd0, 1'b0, 1'b1, 32'hAB}});
      for (int unsigned i = 0; i < 3; i++)
         tbl.push_back('{1'b0, 1'b0, 32'hDEAD_0000, 32'hFFFF_FFFF, 32'hBEEF, 32'h3333, 5'd9, 2'd1, 1'b1,
                         '{32'h3004, 32'h0109_4020, 32'hAB, 32'h2222, 5'd8, 2'd0, 1'b0, 1'b1, 32'hAB}});
      tbl.push_back('{1'b0, 1'b1, 32'h5555, 32'h1, 32'h2, 32'h3, 5'd4, 2'd1, 1'b1, xb});
      tbl.push_back('{1'b1, 1'b0, 32'h3010, 32'h0C00_0C04, 32'h55, 32'h0, 5'd31, 2'd0, 1'b1,
                      '{32'h3010, 32'h0C00_0C04, 32'h55, 32'h0, 5'd31, 2'd0, 1'b1, 1'b1, 32'h3018}});
      tbl.push_back('{1'b1, 1'b0, 32'h3014, 32'h1, 32'hFFFF_FFFF, 32'h7, 5'd0, 2'd0, 1'b0,
                      '{32'h3014, 32'h1, 32'hFFFF_FFFF, 32'h7, 5'd0, 2'd0, 1'b0, 1'b0, 32'hFFFF_FFFF}});
      tbl.push_back('{1'b1, 1'b0, 32'h3018, 32'h2, 32'h40, 32'h0, 5'd3, 2'd1, 1'b0,
                      '{32'h3018, 32'h2, 32'h40, 32'h0, 5'd3, 2'd0, 1'b0, 1'b1, 32'h40}});
      tbl.push_back('{1'b1, 1'b0, 32'h301C, 32'h3, 32'h41, 32'h0, 5'd3, 2'd3, 1'b0,
                      '{32'h301C, 32'h3, 32'h41, 32'h0, 5'd3, 2'd2, 1'b0, 1'b0, 32'h41}});
      tbl.push_back('{1'b1, 1'b1, 32'h3020, 32'h4, 32'h42, 32'h9, 5'd6, 2'd0, 1'b0, xb});
      tbl.push_back('{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h5, 32'h77, 32'h0, 5'd2, 2'd0, 1'b1,
                      '{32'hFFFF_FFFC, 32'h5, 32'h77, 32'h0, 5'd2, 2'd0, 1'b1, 1'b1, 32'h4}});

      // Power-on reset
      drive(1'b1, 1'b0, 32'h1, 32'h1, 32'h1, 32'h1, 5'd1, 2'd0, 1'b1);
      reset = 1'b1;
      #2;
      check("por", xb);
      check_perf("por", 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset between edges clears immediately
      drive(1'b1, 1'b0, 32'h2000, 32'h1234_5678, 32'h1234, 32'h9, 5'd5, 2'd0, 1'b0);
      @(posedge clk); #1;
      check("premid", '{32'h2000, 32'h1234_5678, 32'h1234, 32'h9, 5'd5, 2'd0, 1'b0, 1'b1, 32'h1234});
      #2 reset = 1'b1;
      #1;
      check("midreset", xb);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b1, 1'b0, 32'h2004, 32'h2, 32'h66, 32'h0, 5'd7, 2'd2, 1'b0);
      @(posedge clk); #1;
      check("post_reset_load", '{32'h2004, 32'h2, 32'h66, 32'h0, 5'd7, 2'd1, 1'b0, 1'b0, 32'h66});

      // Table
      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].en, tbl[i].clr, tbl[i].pc, tbl[i].instr, tbl[i].alu,
               tbl[i].rtd, tbl[i].a3, tbl[i].tn, tbl[i].wd);
         @(posedge clk); #1;
         check($sformatf("tbl%0d", i), tbl[i].x);
         if (i == 5) check_perf("hold_flush", 32'h1, 32'h3);
      end

      // Randomized run against the model
      @(negedge clk);
      reset = 1'b1;
      #1;
      reset = 1'b0;
      model_reset();
      for (int unsigned n = 0; n < 400; n++) begin
         @(negedge clk);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom,
               ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom, $urandom, $urandom,
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
               2'($urandom), 1'($urandom));
         model_edge();
         @(posedge clk); #1;
         check($sformatf("rnd%0d", n), model_exp());
         check_perf($sformatf("rnd%0d", n), m_bub, m_hold);
      end

`ifdef EM_PERF_EN
      // Hold counter saturation
      @(negedge clk);
      force dut.u_hold_cnt.count = 32'hFFFF_FFFE;
      #1;
      release dut.u_hold_cnt.count;
      m_hold = 32'hFFFF_FFFE;
      for (int unsigned k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0);
         model_edge();
         @(posedge clk); #1;
         check_cnt($sformatf("hold_sat%0d", k), perf_hold_cnt, 32'hFFFF_FFFF);
      end
      check("hold_sat_state", model_exp());
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
